// File: rtl/count_checker.sv
// -----------------------------------------------------------------------------
// count_checker
// Watches an external 4-bit wrapping counter (0..MAX_COUNT, then back to 0)
// and reports when it breaks sequence. It locks after two consecutive valid
// samples that follow each other. Only a lost sequence while locked is an
// error.
//
// Parameters
//   MAX_COUNT   terminal value of the observed sequence (1..15)
//   ERR_W       width of the saturating error / wrap counters
//
// Ports
//   i_clk        sole clock, all state changes on its rising edge
//   i_reset      synchronous active-high reset, has priority over i_valid
//   i_valid      i_count carries a sample this cycle
//   i_count      observed counter value
//   o_locked     tracking a verified sequence
//   o_err_pulse  one-cycle pulse, the cycle after an offending sample
//   o_err_count  saturating number of detected errors
//   o_wrap_count saturating number of verified MAX_COUNT->0 wraps
//   o_err_flag   sticky error indicator, cleared only by reset
//
// Build option
//   COUNT_CHECKER_STICKY_ERR_EN  when defined, o_err_flag sets with the error
//                                pulse and holds until reset. When undefined,
//                                o_err_flag is tied to 0 and no register is
//                                built for it.
// -----------------------------------------------------------------------------
module count_checker #(
  parameter int unsigned MAX_COUNT = 14,
  parameter int unsigned ERR_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [3:0]       i_count,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic [ERR_W-1:0] o_err_count,
  output logic [ERR_W-1:0] o_wrap_count,
  output logic             o_err_flag
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_COUNT);
  localparam logic [ERR_W-1:0] SAT_V = {ERR_W{1'b1}};

  // FSM encoding
  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_CHECK    = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_expected;
  logic             r_locked;
  logic             r_err_pulse;
  logic [ERR_W-1:0] r_err_count;
  logic [ERR_W-1:0] r_wrap_count;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_expected_nxt;
  logic             w_err;
  logic             w_wrap;
  logic             w_in_range;
  logic             w_match;
  logic [CNT_W-1:0] w_count_nxt;

  // Successor of a value in the wrapping sequence
  function automatic logic [CNT_W-1:0] f_nxt(input logic [CNT_W-1:0] v);
    return (v == MAX_V) ? '0 : v + CNT_W'(1);
  endfunction

  assign w_in_range  = (i_count <= MAX_V);
  assign w_match     = (i_count == r_expected);
  assign w_count_nxt = f_nxt(i_count);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_UNLOCKED;
      r_expected <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_expected <= w_expected_nxt;
    end
  end

  // Next-state, expected-value and event decode
  always_comb begin
    w_state_nxt    = r_state;
    w_expected_nxt = r_expected;
    w_err          = 1'b0;
    w_wrap         = 1'b0;
    if (i_valid) begin
      case (r_state)
        ST_UNLOCKED: begin
          if (w_in_range) begin
            w_expected_nxt = w_count_nxt;
            w_state_nxt    = ST_CHECK;
          end
        end
        ST_CHECK: begin
          // Mismatch here is silent: just re-capture from this sample
          if (w_match) begin
            w_expected_nxt = w_count_nxt;
            w_state_nxt    = ST_LOCKED;
          end else if (w_in_range) begin
            w_expected_nxt = w_count_nxt;
            w_state_nxt    = ST_CHECK;
          end else begin
            w_state_nxt    = ST_UNLOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_match) begin
            w_expected_nxt = w_count_nxt;
            // A matched 0 can only follow MAX_COUNT, i.e. a verified wrap
            w_wrap         = (i_count == '0);
          end else if (w_in_range) begin
            w_err          = 1'b1;
            w_expected_nxt = w_count_nxt;
            w_state_nxt    = ST_CHECK;
          end else begin
            // Out-of-range value: nothing sensible to re-capture
            w_err          = 1'b1;
            w_state_nxt    = ST_UNLOCKED;
          end
        end
        default: begin
          w_state_nxt    = ST_UNLOCKED;
          w_expected_nxt = '0;
        end
      endcase
    end
  end

  // Registered outputs and saturating counters
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_count  <= '0;
      r_wrap_count <= '0;
    end else begin
      r_locked    <= (w_state_nxt == ST_LOCKED);
      r_err_pulse <= w_err;
      if (w_err && (r_err_count != SAT_V)) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
      if (w_wrap && (r_wrap_count != SAT_V)) begin
        r_wrap_count <= r_wrap_count + ERR_W'(1);
      end
    end
  end

  assign o_locked     = r_locked;
  assign o_err_pulse  = r_err_pulse;
  assign o_err_count  = r_err_count;
  assign o_wrap_count = r_wrap_count;

`ifdef COUNT_CHECKER_STICKY_ERR_EN
  logic r_err_flag;

  // Sticky error: set by any detected error, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err_flag <= 1'b0;
    end else if (w_err) begin
      r_err_flag <= 1'b1;
    end
  end

  assign o_err_flag = r_err_flag;
`else
  assign o_err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_count_checker.sv
// -----------------------------------------------------------------------------
// tb_count_checker
// Scoreboard bench for count_checker. Two instances share the stimulus: the
// default one (ERR_W=8) and a narrow one (ERR_W=2) to exercise saturation.
// The reference model tracks the length of the current run of consecutive
// samples: a run of two or more means locked.
// -----------------------------------------------------------------------------
module tb_count_checker;

  localparam int MAXC = 14;

  logic       clk;
  logic       i_reset;
  logic       i_valid;
  logic [3:0] i_count;

  logic       o_locked,  o_err_pulse,  o_err_flag;
  logic [7:0] o_err_count, o_wrap_count;
  logic       n_locked,  n_err_pulse,  n_err_flag;
  logic [1:0] n_err_count, n_wrap_count;

  count_checker #(.MAX_COUNT(MAXC), .ERR_W(8)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_count(i_count),
    .o_locked(o_locked), .o_err_pulse(o_err_pulse), .o_err_count(o_err_count),
    .o_wrap_count(o_wrap_count), .o_err_flag(o_err_flag)
  );

  count_checker #(.MAX_COUNT(MAXC), .ERR_W(2)) dut_n (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_count(i_count),
    .o_locked(n_locked), .o_err_pulse(n_err_pulse), .o_err_count(n_err_count),
    .o_wrap_count(n_wrap_count), .o_err_flag(n_err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit locked;
    bit pulse;
    bit flag;
    int e8;
    int w8;
    int e2;
    int w2;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_run;    // length of current run of in-sequence samples (capped at 2)
  int m_prev;   // last in-range sample of the run
  bit m_pulse, m_flag;
  int m_e8, m_w8, m_e2, m_w2;

  function automatic int nxt(input int v);
    return (v == MAXC) ? 0 : v + 1;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

  task automatic model_err();
    m_pulse = 1'b1;
    m_flag  = 1'b1;
    m_e8 = sat(m_e8, 255);
    m_e2 = sat(m_e2, 3);
  endtask

  task automatic model_step(input bit rst, input bit vld, input int v);
    bit was_locked;
    if (rst) begin
      m_run = 0; m_prev = 0; m_pulse = 0; m_flag = 0;
      m_e8 = 0; m_w8 = 0; m_e2 = 0; m_w2 = 0;
    end else begin
      m_pulse = 1'b0;
      if (vld) begin
        was_locked = (m_run >= 2);
        if (v <= MAXC) begin
          if (m_run >= 1 && v == nxt(m_prev)) begin
            if (was_locked && v == 0) begin
              m_w8 = sat(m_w8, 255);
              m_w2 = sat(m_w2, 3);
            end
            m_run = (m_run >= 2) ? 2 : m_run + 1;
          end else begin
            if (was_locked) model_err();
            m_run = 1;
          end
          m_prev = v;
        end else begin
          if (was_locked) model_err();
          m_run = 0;
        end
      end
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the edge
  task automatic cycle(input bit rst, input bit vld, input int v);
    exp_t e;
    @(negedge clk);
    i_reset = rst;
    i_valid = vld;
    i_count = 4'(v);
    model_step(rst, vld, v);
    e.locked = (m_run >= 2);
    e.pulse  = m_pulse;
`ifdef COUNT_CHECKER_STICKY_ERR_EN
    e.flag   = m_flag;
`else
    e.flag   = 1'b0;
`endif
    e.e8 = m_e8; e.w8 = m_w8; e.e2 = m_e2; e.w2 = m_w2;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: compare every presented output set against the scoreboard
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("locked",       int'(o_locked),     int'(e.locked));
      chk("err_pulse",    int'(o_err_pulse),  int'(e.pulse));
      chk("err_flag",     int'(o_err_flag),   int'(e.flag));
      chk("err_count",    int'(o_err_count),  e.e8);
      chk("wrap_count",   int'(o_wrap_count), e.w8);
      chk("n_locked",     int'(n_locked),     int'(e.locked));
      chk("n_err_pulse",  int'(n_err_pulse),  int'(e.pulse));
      chk("n_err_count",  int'(n_err_count),  e.e2);
      chk("n_wrap_count", int'(n_wrap_count), e.w2);
    end
  end

  initial begin
    int gen_prev;
    int r;
    int v;
    bit vld;
    bit rst;
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_count = 4'd0;
    m_run = 0; m_prev = 0; m_pulse = 0; m_flag = 0;
    m_e8 = 0; m_w8 = 0; m_e2 = 0; m_w2 = 0;

    // Reset, then full sequence 0..14,0,1 with a verified wrap
    cycle(1, 0, 0);
    for (int i = 0; i <= MAXC; i++) cycle(0, 1, i);
    cycle(0, 1, 0);
    cycle(0, 1, 1);
    for (int i = 2; i <= 5; i++) cycle(0, 1, i);
    // Gap of 3 idle cycles while locked
    repeat (3) cycle(0, 0, 0);
    cycle(0, 1, 6);
    cycle(0, 1, 7);
    // Skip: 8 then 10 -> error, 11 re-locks
    cycle(0, 1, 8);
    cycle(0, 1, 10);
    cycle(0, 1, 11);
    cycle(0, 1, 12);
    // Out-of-range while locked, then again while unlocked
    cycle(0, 1, 15);
    cycle(0, 1, 15);
    // Re-lock and walk to 7
    for (int i = 0; i <= 7; i++) cycle(0, 1, i);
    // Reset pulse between two edges: no effect
    cycle(0, 0, 0);
    @(posedge clk);
    #3 i_reset = 1'b1;
    #5 i_reset = 1'b0;
    cycle(0, 1, 8);
    // Reset across an edge with a valid sample: sample discarded
    cycle(1, 1, 9);
    cycle(0, 1, 10);
    cycle(0, 1, 11);
    cycle(0, 1, 12);
    // Five lock/error rounds: narrow counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 2);
      cycle(0, 1, 3);
      cycle(0, 1, 4);
      cycle(0, 1, 9);
    end

    // Randomized traffic: mostly in sequence, with jumps, gaps and resets
    gen_prev = 9;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      rst = (r < 2);
      vld = (r >= 12);
      if (r < 18) v = int'($urandom_range(0, 15));
      else        v = nxt(gen_prev);
      cycle(rst, vld, v);
      if (vld && !rst && v <= MAXC) gen_prev = v;
    end

    // Drain the scoreboard with a bounded wait
    cycle(0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
